ac_rms: RTL and testbench

Block RMS meter that sits directly downstream of the moving-average stage and consumes its signed 16-bit `AC_data` output, i.e. the signal with the DC component removed. It squares each qualified sample and sums N = 2^LOG2_N squares per block. It divides by N with a shift and computes the integer square root sequentially. The result is one unsigned RMS value per block, with a single-cycle valid strobe.

---
 rtl/mov_avr_pkg.sv | 14 +
 rtl/isqrt_seq.sv | 93 +++++++++
 rtl/ac_rms.sv | 82 ++++++++
 tb/tb_ac_rms.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mov_avr_pkg.sv
// Shared definitions for the moving-average / RMS measurement chain.
package mov_avr_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SQ_W     = 31;
    localparam int ROOT_W   = 16;
    localparam int ITER_W   = 4;

    typedef enum logic {
        IDLE,
        CALC
    } rms_state_t;

endpackage

// File: rtl/isqrt_seq.sv
// Restoring bit-serial integer square root: floor(sqrt(radicand)), one result bit per clock, 16 clocks.
module isqrt_seq
    import mov_avr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SQ_W-1:0]   radicand,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root
);

    rms_state_t        state;
    rms_state_t        state_next;
    logic [ITER_W-1:0] iter;
    logic [SQ_W:0]     rad;
    logic [17:0]       rem;
    logic [ROOT_W-1:0] part;
    logic [19:0]       rem_trial;
    logic [19:0]       trial;
    logic              ge;
    logic [17:0]       rem_next;
    logic [ROOT_W-1:0] part_next;
    logic [ROOT_W-1:0] root_q;
    logic              done_q;

    // One iteration: bring down two radicand bits and try subtracting 4*root+1.
    always_comb begin
        rem_trial = {rem, rad[SQ_W:SQ_W-1]};
        trial     = {2'b00, part, 2'b01};
        ge        = (rem_trial >= trial);
        rem_next  = ge ? 18'(rem_trial - trial) : 18'(rem_trial);
        part_next = {part[ROOT_W-2:0], ge};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (iter == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starts are ignored while iterating; the caller flags those as overruns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter   <= '0;
            rad    <= '0;
            rem    <= '0;
            part   <= '0;
            root_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rad  <= {1'b0, radicand};
                        rem  <= '0;
                        part <= '0;
                        iter <= '1;
                    end
                end
                CALC: begin
                    rad  <= {rad[SQ_W-2:0], 2'b00};
                    rem  <= rem_next;
                    part <= part_next;
                    iter <= iter - 1'b1;
                    if (iter == '0) begin
                        root_q <= part_next;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/ac_rms.sv
// Block RMS meter: squares qualified AC samples, sums 2^LOG2_N of them, and takes the root of the mean.
module ac_rms
    import mov_avr_pkg::*;
#(
    parameter int LOG2_N = 10
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                clk_en,
    input  logic [SAMPLE_W-1:0] ac_data,
    output logic [ROOT_W-1:0]   rms,
    output logic                rms_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int ACC_W = SQ_W + LOG2_N;

    logic [SQ_W-1:0]   ext;
    logic [SQ_W-1:0]   sq;
    logic              sq_v;
    logic [ACC_W-1:0]  acc;
    logic [LOG2_N-1:0] cnt;
    logic [ACC_W-1:0]  total;
    logic              block_close;
    logic [SQ_W-1:0]   mean;
    logic              eng_busy;

    // Modular 31-bit product of the sign-extended sample equals the true square (at most 2^30).
    assign ext = {{(SQ_W - SAMPLE_W){ac_data[SAMPLE_W-1]}}, ac_data};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sq   <= '0;
            sq_v <= 1'b0;
        end else begin
            sq   <= ext * ext;
            sq_v <= clk_en;
        end
    end

    assign block_close = sq_v && (cnt == '1);
    assign total       = acc + ACC_W'(sq);
    assign mean        = SQ_W'(total >> LOG2_N);

    // The closing sample is folded into total and the next block starts from zero on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (sq_v) begin
            if (block_close) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= total;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overrun <= 1'b0;
        end else if (block_close && eng_busy) begin
            overrun <= 1'b1;
        end
    end

    isqrt_seq u_isqrt (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .start    (block_close),
        .radicand (mean),
        .busy     (eng_busy),
        .done     (rms_valid),
        .root     (rms)
    );

    assign busy = eng_busy;

endmodule

// File: tb/tb_ac_rms.sv
// Directed self-checking bench for ac_rms with LOG2_N=2 (four samples per block).
module tb_ac_rms;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        clk_en;
    logic [15:0] ac_data;
    logic [15:0] rms;
    logic        rms_valid;
    logic        busy;
    logic        overrun;

    int checks;
    int failures;

    ac_rms #(.LOG2_N(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_en    (clk_en),
        .ac_data   (ac_data),
        .rms       (rms),
        .rms_valid (rms_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents one sample for one accept edge, then idles gap cycles; returns #1 after the last edge.
    task automatic applyStimulus(input logic [15:0] value, input int gap);
        clk_en  = 1'b1;
        ac_data = value;
        @(posedge sys_clk);
        #1;
        clk_en  = 1'b0;
        ac_data = 16'd0;
        repeat (gap) @(posedge sys_clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rms"}, {16'd0, rms}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, rms_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    // Sends a full block (last sample without trailing gap) and checks latency, value and busy.
    task automatic runBlock(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                            input logic [15:0] s3, input int gap, input string tag, input int expected);
        int          latency;
        logic [15:0] value;
        logic        busy_launch;
        latency     = -1;
        value       = 16'hxxxx;
        busy_launch = 1'bx;
        applyStimulus(s0, gap);
        applyStimulus(s1, gap);
        applyStimulus(s2, gap);
        applyStimulus(s3, 0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge sys_clk);
            #1;
            if (c == 1) busy_launch = busy;
            if (rms_valid) begin
                latency = c;
                value   = rms;
                break;
            end
        end
        checkOutput({tag, "_latency"}, latency, 32'd17);
        checkOutput({tag, "_rms"}, {16'd0, value}, expected);
        checkOutput({tag, "_busy_launch"}, {31'd0, busy_launch}, 32'd1);
        checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int ovr_cycle;
        int first_cycle;
        int valid_count;
        logic [15:0] first_val;

        checks    = 0;
        failures  = 0;
        sys_rst_n = 1'b0;
        clk_en    = 1'b0;
        ac_data   = 16'd0;

        #12;
        checkAllZero("reset");
        #11;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        $display("[TB] block of 100 at 1-in-8");
        runBlock(16'd100, 16'd100, 16'd100, 16'd100, 7, "avg100", 100);
        checkOutput("avg100_pulse_one_cycle", {31'd0, rms_valid}, 32'd0);
        checkOutput("avg100_rms_hold", {16'd0, rms}, 32'd100);

        $display("[TB] alternating +-1000");
        runBlock(16'd1000, -16'sd1000, 16'd1000, -16'sd1000, 7, "alt1000", 1000);

        $display("[TB] full-scale negative");
        runBlock(16'h8000, 16'h8000, 16'h8000, 16'h8000, 7, "fullscale", 32768);

        $display("[TB] 3,4,0,0 then zeros");
        runBlock(16'd3, 16'd4, 16'd0, 16'd0, 7, "floor", 2);
        runBlock(16'd0, 16'd0, 16'd0, 16'd0, 7, "zeros", 0);

        checkOutput("overrun_clear_before", {31'd0, overrun}, 32'd0);

        $display("[TB] continuous samples of 10");
        ovr_cycle   = -1;
        first_cycle = -1;
        valid_count = 0;
        first_val   = 16'hxxxx;
        clk_en      = 1'b1;
        ac_data     = 16'd10;
        for (int c = 1; c <= 60; c++) begin
            @(posedge sys_clk);
            #1;
            if (c == 20) begin
                clk_en  = 1'b0;
                ac_data = 16'd0;
            end
            if (overrun && ovr_cycle < 0) ovr_cycle = c;
            if (rms_valid) begin
                valid_count++;
                if (first_cycle < 0) begin
                    first_cycle = c;
                    first_val   = rms;
                end
            end
        end
        checkOutput("cont_first_cycle", first_cycle, 32'd21);
        checkOutput("cont_first_rms", {16'd0, first_val}, 32'd10);
        checkOutput("cont_overrun_cycle", ovr_cycle, 32'd9);
        checkOutput("cont_valid_count", valid_count, 32'd1);
        checkOutput("cont_overrun_sticky", {31'd0, overrun}, 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(16'd200, 7);
        applyStimulus(16'd200, 7);
        applyStimulus(16'd200, 7);
        applyStimulus(16'd200, 0);
        applyStimulus(16'd7000, 0);
        applyStimulus(16'd7000, 0);
        @(posedge sys_clk);
        #1;
        checkOutput("midreset_busy_before", {31'd0, busy}, 32'd1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        checkAllZero("inreset");
        @(posedge sys_clk);
        #1;
        checkAllZero("inreset_edge");
        #2;
        sys_rst_n = 1'b1;
        valid_count = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge sys_clk);
            #1;
            if (rms_valid) valid_count++;
        end
        checkOutput("postreset_no_valid", valid_count, 32'd0);
        runBlock(16'd50, 16'd50, 16'd50, 16'd50, 7, "after_reset", 50);
        checkOutput("after_reset_overrun", {31'd0, overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
